// File: rtl/bp_be_sys_arbiter.sv
// bp_be_sys_arbiter
//
// Serializes system instructions (CSR ops, fences, traps) from the two issue
// lanes onto the single system pipe. Exactly one system instruction is in
// flight at a time. A one-entry hold buffer absorbs a same-cycle lane 1
// request so a dual-issue pair does not stall the issue stage.
//
// Ports:
//   clk_i            clock, all state on posedge
//   reset_i          asynchronous, active-high reset
//   lane0_v_i        older-lane request valid
//   lane0_payload_i  older-lane payload
//   lane0_ready_o    lane 0 accepted when lane0_v_i & lane0_ready_o
//   lane1_v_i        younger-lane request valid
//   lane1_payload_i  younger-lane payload
//   lane1_ready_o    lane 1 accepted when lane1_v_i & lane1_ready_o
//   flush_i          kills issued, held and incoming work
//   retire_v_i       in-flight system instruction retired
//   sys_v_o          one-cycle issue pulse to the system pipe
//   sys_payload_o    payload of the issued instruction
//   sys_lane_o       source lane of the issued instruction
//   busy_o           arbiter not idle or hold buffer occupied
//   hang_o           sticky: WAIT lasted timeout_p cycles
module bp_be_sys_arbiter #(
  parameter int payload_width_p = 128,
  parameter int timeout_p       = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       lane0_v_i,
  input  logic [payload_width_p-1:0] lane0_payload_i,
  output logic                       lane0_ready_o,
  input  logic                       lane1_v_i,
  input  logic [payload_width_p-1:0] lane1_payload_i,
  output logic                       lane1_ready_o,
  input  logic                       flush_i,
  input  logic                       retire_v_i,
  output logic                       sys_v_o,
  output logic [payload_width_p-1:0] sys_payload_o,
  output logic                       sys_lane_o,
  output logic                       busy_o,
  output logic                       hang_o
);

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_issue = 2'd1,
    e_wait  = 2'd2
  } state_e;

  localparam int cnt_width_lp = $clog2(timeout_p + 1);
  localparam logic [cnt_width_lp-1:0] timeout_lp = cnt_width_lp'(timeout_p);

  state_e                      state_r;
  logic [payload_width_p-1:0]  issue_payload_r;
  logic                        lane_r;
  logic                        hold_v_r;
  logic [payload_width_p-1:0]  hold_payload_r;
  logic [cnt_width_lp-1:0]     wait_cnt_r;
  logic                        hang_r;

  logic ready;
  logic accept0, accept1;

  assign ready   = (state_r == e_idle) & ~hold_v_r & ~flush_i;
  assign accept0 = lane0_v_i & ready;
  assign accept1 = lane1_v_i & ready;

  assign lane0_ready_o = ready;
  assign lane1_ready_o = ready;

  // The issue pulse is a decode of the ISSUE state, but a same-cycle flush
  // must suppress it, so flush_i gates it combinationally.
  assign sys_v_o       = (state_r == e_issue) & ~flush_i;
  assign sys_payload_o = issue_payload_r;
  assign sys_lane_o    = lane_r;
  assign busy_o        = (state_r != e_idle) | hold_v_r;
  assign hang_o        = hang_r;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r         <= e_idle;
      issue_payload_r <= '0;
      lane_r          <= 1'b0;
      hold_v_r        <= 1'b0;
      hold_payload_r  <= '0;
      wait_cnt_r      <= '0;
      hang_r          <= 1'b0;
    end else begin
      // Watchdog: runs on every WAIT cycle; cleared while in ISSUE, which is
      // the only way into WAIT.
      if (state_r == e_issue) begin
        wait_cnt_r <= '0;
      end else if (state_r == e_wait) begin
        if (wait_cnt_r != timeout_lp) wait_cnt_r <= wait_cnt_r + 1'b1;
        if (wait_cnt_r >= timeout_lp - 1'b1) hang_r <= 1'b1;
      end

      if (flush_i) begin
        // Flush outranks retire and drops any held younger-lane work.
        state_r  <= e_idle;
        hold_v_r <= 1'b0;
      end else begin
        case (state_r)
          e_idle: begin
            if (accept0) begin
              issue_payload_r <= lane0_payload_i;
              lane_r          <= 1'b0;
              state_r         <= e_issue;
              if (accept1) begin
                hold_v_r       <= 1'b1;
                hold_payload_r <= lane1_payload_i;
              end
            end else if (accept1) begin
              issue_payload_r <= lane1_payload_i;
              lane_r          <= 1'b1;
              state_r         <= e_issue;
            end
          end
          e_issue: state_r <= e_wait;
          e_wait: begin
            if (retire_v_i) begin
              if (hold_v_r) begin
                issue_payload_r <= hold_payload_r;
                lane_r          <= 1'b1;
                hold_v_r        <= 1'b0;
                state_r         <= e_issue;
              end else begin
                state_r <= e_idle;
              end
            end
          end
          default: state_r <= e_idle;
        endcase
      end
    end
  end

endmodule
